// File: rtl/issue_queue.sv
// Single-issue, age-ordered collapsing issue queue. Slot 0 holds the oldest entry.
// The oldest entry with both sources ready is presented on the issue port. Its
// destination is echoed on sel_dest when it fires, so the busy table and the
// wakeup network see it in the same cycle.
module issue_queue #(
  parameter int DEPTH      = 8,
  parameter int REG_ADDR_W = 5,
  parameter int PAYLOAD_W  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  output logic                  enq_ready,
  input  logic                  enq1_valid,
  input  logic [REG_ADDR_W-1:0] enq1_src1,
  input  logic                  enq1_src1_ready,
  input  logic [REG_ADDR_W-1:0] enq1_src2,
  input  logic                  enq1_src2_ready,
  input  logic [REG_ADDR_W-1:0] enq1_dest,
  input  logic                  enq1_rf_we,
  input  logic [PAYLOAD_W-1:0]  enq1_payload,
  input  logic                  enq2_valid,
  input  logic [REG_ADDR_W-1:0] enq2_src1,
  input  logic                  enq2_src1_ready,
  input  logic [REG_ADDR_W-1:0] enq2_src2,
  input  logic                  enq2_src2_ready,
  input  logic [REG_ADDR_W-1:0] enq2_dest,
  input  logic                  enq2_rf_we,
  input  logic [PAYLOAD_W-1:0]  enq2_payload,
  input  logic [REG_ADDR_W-1:0] wake_dest0,
  input  logic [REG_ADDR_W-1:0] wake_dest1,
  input  logic [REG_ADDR_W-1:0] wake_dest2,
  input  logic [REG_ADDR_W-1:0] wake_dest3,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [PAYLOAD_W-1:0]  issue_payload,
  output logic [REG_ADDR_W-1:0] issue_dest,
  output logic                  issue_rf_we,
  output logic [REG_ADDR_W-1:0] sel_dest
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]      valid_q, src1_rdy_q, src2_rdy_q, rf_we_q;
  logic [REG_ADDR_W-1:0] src1_q [DEPTH];
  logic [REG_ADDR_W-1:0] src2_q [DEPTH];
  logic [REG_ADDR_W-1:0] dest_q [DEPTH];
  logic [PAYLOAD_W-1:0]  payload_q [DEPTH];
  logic [CNT_W-1:0]      count_q;

  logic [DEPTH-1:0]      valid_n, src1_rdy_n, src2_rdy_n, rf_we_n;
  logic [REG_ADDR_W-1:0] src1_n [DEPTH];
  logic [REG_ADDR_W-1:0] src2_n [DEPTH];
  logic [REG_ADDR_W-1:0] dest_n [DEPTH];
  logic [PAYLOAD_W-1:0]  payload_n [DEPTH];
  logic [CNT_W-1:0]      count_n;

  logic             found;
  logic [IDX_W-1:0] sel_idx;
  logic             fire;
  logic             enq1_acc, enq2_acc;
  logic [CNT_W-1:0] base;
  logic [IDX_W-1:0] slot1, slot2;

  // A tag of 0 means "no wakeup" on that port, so it never matches.
  function automatic logic wake_hit(input logic [REG_ADDR_W-1:0] tag, w0, w1, w2, w3);
    return (tag != '0) && ((tag == w0) || (tag == w1) || (tag == w2) || (tag == w3));
  endfunction

  // Oldest-first select: scanning from the top lets the lowest ready index win.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && src1_rdy_q[i] && src2_rdy_q[i]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign issue_valid   = found && !flush;
  assign fire          = issue_valid && issue_ready;
  assign issue_payload = issue_valid ? payload_q[sel_idx] : '0;
  assign issue_dest    = issue_valid ? dest_q[sel_idx] : '0;
  assign issue_rf_we   = issue_valid && rf_we_q[sel_idx];
  assign sel_dest      = (fire && issue_rf_we) ? issue_dest : '0;

  // Room for a full pair is judged on the registered count only; a fire this
  // cycle does not free space until the next one.
  assign enq_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign enq1_acc  = enq1_valid && enq_ready && !flush;
  assign enq2_acc  = enq2_valid && enq_ready && !flush;

  assign base  = count_q - CNT_W'(fire);
  assign slot1 = IDX_W'(base);
  assign slot2 = slot1 + IDX_W'(enq1_acc);

  // Next queue image: collapse over the fired slot, apply wakeups, append enqueues.
  always_comb begin
    valid_n    = valid_q;
    src1_rdy_n = src1_rdy_q;
    src2_rdy_n = src2_rdy_q;
    rf_we_n    = rf_we_q;
    src1_n     = src1_q;
    src2_n     = src2_q;
    dest_n     = dest_q;
    payload_n  = payload_q;

    if (fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i >= int'(sel_idx)) begin
          valid_n[i]    = valid_q[i+1];
          src1_rdy_n[i] = src1_rdy_q[i+1];
          src2_rdy_n[i] = src2_rdy_q[i+1];
          rf_we_n[i]    = rf_we_q[i+1];
          src1_n[i]     = src1_q[i+1];
          src2_n[i]     = src2_q[i+1];
          dest_n[i]     = dest_q[i+1];
          payload_n[i]  = payload_q[i+1];
        end
      end
      valid_n[DEPTH-1] = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (wake_hit(src1_n[i], wake_dest0, wake_dest1, wake_dest2, wake_dest3))
        src1_rdy_n[i] = 1'b1;
      if (wake_hit(src2_n[i], wake_dest0, wake_dest1, wake_dest2, wake_dest3))
        src2_rdy_n[i] = 1'b1;
    end

    // Same-cycle wakeups are bypassed into the new entry so a tag cleared in
    // the busy table this cycle is not lost.
    if (enq1_acc) begin
      valid_n[slot1]    = 1'b1;
      src1_n[slot1]     = enq1_src1;
      src2_n[slot1]     = enq1_src2;
      dest_n[slot1]     = enq1_dest;
      rf_we_n[slot1]    = enq1_rf_we;
      payload_n[slot1]  = enq1_payload;
      src1_rdy_n[slot1] = enq1_src1_ready || (enq1_src1 == '0) ||
                          wake_hit(enq1_src1, wake_dest0, wake_dest1, wake_dest2, wake_dest3);
      src2_rdy_n[slot1] = enq1_src2_ready || (enq1_src2 == '0) ||
                          wake_hit(enq1_src2, wake_dest0, wake_dest1, wake_dest2, wake_dest3);
    end
    if (enq2_acc) begin
      valid_n[slot2]    = 1'b1;
      src1_n[slot2]     = enq2_src1;
      src2_n[slot2]     = enq2_src2;
      dest_n[slot2]     = enq2_dest;
      rf_we_n[slot2]    = enq2_rf_we;
      payload_n[slot2]  = enq2_payload;
      src1_rdy_n[slot2] = enq2_src1_ready || (enq2_src1 == '0) ||
                          wake_hit(enq2_src1, wake_dest0, wake_dest1, wake_dest2, wake_dest3);
      src2_rdy_n[slot2] = enq2_src2_ready || (enq2_src2 == '0) ||
                          wake_hit(enq2_src2, wake_dest0, wake_dest1, wake_dest2, wake_dest3);
    end

    if (flush) valid_n = '0;
  end

  assign count_n = flush ? '0
                 : count_q - CNT_W'(fire) + CNT_W'(enq1_acc) + CNT_W'(enq2_acc);

  // Queue state registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      rf_we_q    <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src1_q[i]    <= '0;
        src2_q[i]    <= '0;
        dest_q[i]    <= '0;
        payload_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_n;
      src1_rdy_q <= src1_rdy_n;
      src2_rdy_q <= src2_rdy_n;
      rf_we_q    <= rf_we_n;
      count_q    <= count_n;
      src1_q     <= src1_n;
      src2_q     <= src2_n;
      dest_q     <= dest_n;
      payload_q  <= payload_n;
    end
  end

endmodule
